fsqrt_sched: RTL and testbench

Shares one `fsqrt` pipeline among `NREQ` requesters (FPU issue ports, e.g. the main core and a vector helper). Each requester uses a valid/ready request channel. The block does round-robin arbitration and issues at most one operand per cycle into the fixed-latency `fsqrt`, which has no stall input. Results are tagged with the requester index and returned through a credit-protected result FIFO on one shared response channel with backpressure.

---
 rtl/fpu_pkg.sv | 23 ++
 rtl/fsqrt.sv | 88 ++++++++
 rtl/fsqrt_rr_pick.sv | 33 +++
 rtl/fsqrt_sched.sv | 185 ++++++++++++++++++
 tb/tb_fsqrt_sched.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: square-root pipeline latency and the tagged
// response entry held in the scheduler's result FIFO.
package fpu_pkg;

   // Cycles from the fsqrt operand sample edge to a valid result
   localparam int FSQRT_LATENCY = 1;

   // Widest requester id the scheduler supports (NREQ up to 8)
   localparam int RSP_ID_W = 3;

   // Quiet NaN produced for invalid square-root operands
   localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

   // Positive infinity
   localparam logic [31:0] FP32_PINF = 32'h7F80_0000;

   // One buffered result: owning requester and its square root
   typedef struct packed {
      logic [RSP_ID_W-1:0] id;
      logic [31:0]         y;
   } fsqrt_rsp_t;

endpackage

// File: rtl/fsqrt.sv
// Single-precision square root with one cycle of latency.
// Denormal inputs flush to a signed zero; negative non-zero inputs and NaNs
// give a quiet NaN; +inf passes through. Round-to-nearest-even on the root.
module fsqrt
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] x1,
   output logic [31:0] y
);

   logic [31:0] y_q;
   logic [31:0] y_d;

   logic        sign_in;
   logic [7:0]  exp_in;
   logic [22:0] frac_in;
   logic [23:0] mant_in;
   logic [49:0] radicand;
   logic [27:0] rem;
   logic [27:0] trial;
   logic [24:0] root;
   logic        rnd_up;
   logic [24:0] mant_rnd;
   logic        mant_unused_hidden;
   logic [8:0]  exp_sum;
   logic [7:0]  exp_out;
   logic [22:0] frac_out;

   // Digit-by-digit integer root of the aligned mantissa, then rounding and
   // special-case selection for the next result
   always_comb begin
      sign_in  = x1[31];
      exp_in   = x1[30:23];
      frac_in  = x1[22:0];
      mant_in  = {1'b1, frac_in};

      // An even biased exponent means an odd unbiased one, so the mantissa is
      // doubled to keep the halved exponent integral
      radicand = exp_in[0] ? {1'b0, mant_in, 25'd0} : {mant_in, 26'd0};

      rem   = '0;
      trial = '0;
      root  = '0;
      for (int i = 24; i >= 0; i--) begin
         rem   = {rem[25:0], radicand[2*i +: 2]};
         trial = {1'b0, root, 2'b01};
         if (rem >= trial) begin
            rem  = rem - trial;
            root = {root[23:0], 1'b1};
         end else begin
            root = {root[23:0], 1'b0};
         end
      end

      // root[0] is the guard bit; any remainder acts as sticky
      rnd_up   = root[0] & ((rem != '0) | root[1]);
      mant_rnd = {1'b0, root[24:1]} + 25'(rnd_up);
      mant_unused_hidden = mant_rnd[23];

      exp_sum  = {1'b0, exp_in} + (exp_in[0] ? 9'd127 : 9'd126);
      exp_out  = exp_sum[8:1] + {7'd0, mant_rnd[24]};
      frac_out = mant_rnd[24] ? 23'd0 : mant_rnd[22:0];

      if (exp_in == 8'd0) begin
         y_d = {sign_in, 31'd0};
      end else if (exp_in == 8'hFF) begin
         y_d = ((frac_in != '0) || sign_in) ? FP32_QNAN : FP32_PINF;
      end else if (sign_in) begin
         y_d = FP32_QNAN;
      end else begin
         y_d = {1'b0, exp_out, frac_out};
      end
   end

   // Result register; this pipeline uses a synchronous reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         y_q <= '0;
      end else begin
         y_q <= y_d;
      end
   end

   assign y = y_q;

endmodule

// File: rtl/fsqrt_rr_pick.sv
// Combinational round-robin picker: grants the first active request found
// scanning upward from ptr with wrap-around, only while en is high.
module fsqrt_rr_pick #(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id
);

   logic [IDW-1:0] idx;
   logic           found;

   // Scan every position once starting at ptr; the first hit wins
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(ptr) + k) % NREQ);
         if (en && !found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = idx;
         end
      end
   end

endmodule

// File: rtl/fsqrt_sched.sv
// Shares one fixed-latency fsqrt among NREQ requesters. Round-robin issue,
// a tag shift register that tracks each operand through the pipeline, and a
// credit-protected result FIFO feeding a single response channel.
module fsqrt_sched
   import fpu_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int LATENCY = FSQRT_LATENCY,
   parameter int DEPTH   = 4,
   parameter int IDW     = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_x,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          rsp_y,
   input  logic                 rsp_ready,
   output logic                 busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + LATENCY + 1);

   // Round-robin pointer
   logic [IDW-1:0]              rr_ptr_q;
   logic [IDW-1:0]              rr_ptr_d;

   // Tag shift register, stage 0 is the operand just issued
   logic [LATENCY-1:0]          tag_vld_q;
   logic [LATENCY-1:0]          tag_vld_d;
   logic [LATENCY-1:0][IDW-1:0] tag_id_q;
   logic [LATENCY-1:0][IDW-1:0] tag_id_d;

   // Result FIFO
   fsqrt_rsp_t                  mem_q [DEPTH];
   fsqrt_rsp_t                  mem_d [DEPTH];
   logic [PW-1:0]               wr_ptr_q;
   logic [PW-1:0]               wr_ptr_d;
   logic [PW-1:0]               rd_ptr_q;
   logic [PW-1:0]               rd_ptr_d;
   logic [CW-1:0]               fifo_cnt_q;
   logic [CW-1:0]               fifo_cnt_d;

   logic [CW-1:0]               inflight;
   logic [CW-1:0]               occupancy;
   logic                        can_issue;
   logic                        accept;
   logic                        push;
   logic                        pop;
   logic [NREQ-1:0]             gnt;
   logic [IDW-1:0]              gnt_id;
   logic [31:0]                 sqrt_x1;
   logic [31:0]                 sqrt_y;
   fsqrt_rsp_t                  push_entry;
   fsqrt_rsp_t                  head_entry;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Count the operands still inside the pipeline
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) begin
         inflight = inflight + CW'(tag_vld_q[i]);
      end
   end

   // Every issued operand owns a FIFO slot until it is popped, so a pop
   // this cycle frees nothing until the next cycle
   assign occupancy = fifo_cnt_q + inflight;
   assign can_issue = occupancy < CW'(DEPTH);

   fsqrt_rr_pick #(
      .NREQ   (NREQ),
      .IDW    (IDW)
   ) u_pick (
      .req    (req_valid),
      .ptr    (rr_ptr_q),
      .en     (can_issue & rstn),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign req_ready = gnt;
   assign accept    = |gnt;

   // Steer the granted operand into the pipeline; idle cycles feed zero
   always_comb begin
      sqrt_x1 = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sqrt_x1 = sqrt_x1 | req_x[32*i +: 32];
         end
      end
   end

   fsqrt u_fsqrt (
      .clk  (clk),
      .rstn (rstn),
      .x1   (sqrt_x1),
      .y    (sqrt_y)
   );

   // Advance the round-robin pointer past the requester just served
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      end
   end

   // Shift the issue tag alongside the operand; the tag leaving the last
   // stage lines up with the fsqrt result
   always_comb begin
      tag_vld_d    = '0;
      tag_id_d     = '0;
      tag_vld_d[0] = accept;
      tag_id_d[0]  = gnt_id;
      for (int i = 1; i < LATENCY; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end
   end

   assign push = tag_vld_q[LATENCY-1];
   assign pop  = rsp_valid & rsp_ready;

   // Build the tagged entry captured when a result leaves the pipeline
   always_comb begin
      push_entry    = '0;
      push_entry.id = RSP_ID_W'(tag_id_q[LATENCY-1]);
      push_entry.y  = sqrt_y;
   end

   // FIFO bookkeeping for push and pop, which may happen together
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_entry;
      end
      wr_ptr_d   = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
   end

   // Control state: pointer, tags and FIFO indices, cleared by reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr_q   <= '0;
         tag_vld_q  <= '0;
         tag_id_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         tag_vld_q  <= tag_vld_d;
         tag_id_q   <= tag_id_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   // FIFO storage needs no reset; the response outputs are masked when empty
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head_entry = mem_q[rd_ptr_q];
   assign rsp_valid  = fifo_cnt_q != '0;
   assign rsp_id     = rsp_valid ? IDW'(head_entry.id) : '0;
   assign rsp_y      = rsp_valid ? head_entry.y : '0;
   assign busy       = rsp_valid | (|tag_vld_q);

   // Credit accounting must make a push into a full FIFO impossible
   a_no_push_when_full : assert property (
      @(posedge clk) disable iff (!rstn) !(push && (fifo_cnt_q == CW'(DEPTH))))
      else $error("fsqrt_sched: result pushed into a full FIFO");

endmodule

// File: tb/tb_fsqrt_sched.sv
// Bench for fsqrt_sched: a reference model of round-robin issue, credit and
// response timing, with a scoreboard of expected results in issue order.
module tb_fsqrt_sched;

   localparam int NREQ    = 2;
   localparam int LATENCY = 1;
   localparam int DEPTH   = 4;
   localparam int IDW     = 1;

   logic                 clk;
   logic                 rstn;
   logic [NREQ-1:0]      req_valid;
   logic [32*NREQ-1:0]   req_x;
   logic [NREQ-1:0]      req_ready;
   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [31:0]          rsp_y;
   logic                 rsp_ready;
   logic                 busy;

   typedef struct {
      logic [IDW-1:0] id;
      logic [31:0]    y;
      int             cyc;
   } exp_t;

   exp_t sb[$];
   int   checks;
   int   failures;
   int   cyc;
   int   ptr_m;

   fsqrt_sched #(
      .NREQ      (NREQ),
      .LATENCY   (LATENCY),
      .DEPTH     (DEPTH),
      .IDW       (IDW)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_x     (req_x),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Operands with exactly representable roots
   function automatic logic [31:0] opTable(input int i);
      case (i)
         0:       return 32'h4080_0000;   // 4.0
         1:       return 32'h4180_0000;   // 16.0
         2:       return 32'h3F80_0000;   // 1.0
         3:       return 32'h0000_0000;   // 0.0
         4:       return 32'h4110_0000;   // 9.0
         5:       return 32'h4280_0000;   // 64.0
         6:       return 32'h3E80_0000;   // 0.25
         default: return 32'h4010_0000;   // 2.25
      endcase
   endfunction

   function automatic logic [31:0] sqrtRef(input logic [31:0] x);
      case (x)
         32'h4080_0000: return 32'h4000_0000;
         32'h4180_0000: return 32'h4080_0000;
         32'h3F80_0000: return 32'h3F80_0000;
         32'h0000_0000: return 32'h0000_0000;
         32'h4110_0000: return 32'h4040_0000;
         32'h4280_0000: return 32'h4100_0000;
         32'h3E80_0000: return 32'h3F00_0000;
         32'h4010_0000: return 32'h3FC0_0000;
         default:       return 32'hFFFF_FFFF;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
      end
   endtask

   // Compare this cycle's outputs with the model, then advance the model
   // through the coming clock edge
   task automatic sampleCycle();
      logic [NREQ-1:0] exp_gnt;
      logic [IDW-1:0]  idx;
      logic [IDW-1:0]  gid;
      logic            exp_rv;
      logic [31:0]     gx;
      if (!rstn) begin
         sb.delete();
         ptr_m = 0;
         checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
         checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         checkOutput("rst_rsp_id",    32'(rsp_id),    32'd0);
         checkOutput("rst_rsp_y",     rsp_y,          32'd0);
         checkOutput("rst_busy",      32'(busy),      32'd0);
      end else begin
         exp_gnt = '0;
         gid     = '0;
         if (sb.size() < DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
               idx = IDW'((ptr_m + k) % NREQ);
               if (exp_gnt == '0 && req_valid[idx]) begin
                  exp_gnt[idx] = 1'b1;
                  gid          = idx;
               end
            end
         end
         checkOutput("req_ready", 32'(req_ready), 32'(exp_gnt));
         exp_rv = (sb.size() != 0) && (cyc >= sb[0].cyc + LATENCY + 1);
         checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
         checkOutput("busy", 32'(busy), 32'(sb.size() != 0));
         if (exp_rv && rsp_valid) begin
            checkOutput("rsp_id", 32'(rsp_id), 32'(sb[0].id));
            checkOutput("rsp_y",  rsp_y,       sb[0].y);
         end
         if (exp_rv && rsp_ready) begin
            void'(sb.pop_front());
         end
         if (exp_gnt != '0) begin
            gx = gid ? req_x[63:32] : req_x[31:0];
            sb.push_back('{id: gid, y: sqrtRef(gx), cyc: cyc});
            ptr_m = (int'(gid) + 1) % NREQ;
         end
      end
      cyc++;
   endtask

   // Drive one input pattern for n cycles; entered and left at a falling edge
   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [31:0] x0,
                                input logic [31:0] x1, input logic rr, input int n);
      for (int i = 0; i < n; i++) begin
         req_valid = v;
         req_x     = {x1, x0};
         rsp_ready = rr;
         #3;
         sampleCycle();
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      checks    = 0;
      failures  = 0;
      cyc       = 0;
      ptr_m     = 0;
      rstn      = 1'b0;
      req_valid = '0;
      req_x     = '0;
      rsp_ready = 1'b0;
      @(negedge clk);

      $display("[TB] reset");
      applyStimulus(2'b11, 32'h4080_0000, 32'h4080_0000, 1'b1, 2);
      rstn = 1'b1;

      $display("[TB] single request");
      applyStimulus(2'b01, 32'h4080_0000, 32'h0, 1'b1, 1);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 4);

      $display("[TB] contention");
      applyStimulus(2'b11, 32'h4180_0000, 32'h3F80_0000, 1'b1, 8);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 4);

      $display("[TB] backpressure and hold");
      applyStimulus(2'b10, 32'h0, 32'h4110_0000, 1'b0, 8);
      applyStimulus(2'b10, 32'h0, 32'h4280_0000, 1'b1, 6);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 5);

      $display("[TB] zero operand");
      applyStimulus(2'b01, 32'h0000_0000, 32'h0, 1'b1, 1);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 3);

      $display("[TB] reset mid-flight");
      applyStimulus(2'b11, 32'h4280_0000, 32'h3E80_0000, 1'b0, 2);
      rstn = 1'b0;
      applyStimulus(2'b11, 32'h4280_0000, 32'h3E80_0000, 1'b1, 1);
      rstn = 1'b1;
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 3);
      applyStimulus(2'b11, 32'h4010_0000, 32'h3E80_0000, 1'b1, 4);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 4);

      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++) begin
         applyStimulus(NREQ'($urandom_range(0, 3)),
                       opTable(int'($urandom_range(0, 7))),
                       opTable(int'($urandom_range(0, 7))),
                       $urandom_range(0, 9) < 7, 1);
      end

      $display("[TB] drain");
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
